// File: rtl/tone_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// tone_sequencer_pkg
//   Shared types and constants for the tone sequencer and its step table.
//   - state_t        : sequencer FSM states
//   - step_t         : one table entry {count_to, dur}
//   - END_MARKER_DUR : dur value that terminates a sequence
//   - state_flags()  : registered status flags implied by a state
// -----------------------------------------------------------------------------
package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // count_to sits in the upper half so {count_to, dur} concatenations line up.
    typedef struct packed {
        logic [31:0] count_to;
        logic [31:0] dur;
    } step_t;

    localparam logic [31:0] END_MARKER_DUR = 32'd0;

    // Status flags as a function of the state being entered:
    // {div_reset, tone_on, busy, done}. The divider only runs during PLAY.
    function automatic logic [3:0] state_flags(input state_t s);
        case (s)
            ST_IDLE: state_flags = 4'b1000;
            ST_LOAD: state_flags = 4'b1010;
            ST_PLAY: state_flags = 4'b0110;
            ST_DONE: state_flags = 4'b1001;
            default: state_flags = 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/tone_sequencer_step_table.sv
// -----------------------------------------------------------------------------
// tone_sequencer_step_table
//   N_STEPS x 64-bit register file holding the tone sequence.
//   Synchronous write, synchronous clear on reset, and two combinational
//   read ports: the entry at rd_idx and the entry after it (wrapping).
//   The wrapped "next" read at the last index is harmless: the sequencer
//   checks for the last index before looking at the next entry.
//
// Ports:
//   CLK_50M   in   system clock
//   reset     in   synchronous, active-high; clears every entry
//   wr_en     in   write strobe (already gated by the sequencer)
//   wr_addr   in   entry written
//   wr_data   in   entry contents
//   rd_idx    in   current entry index
//   cur_step  out  table[rd_idx]
//   nxt_step  out  table[rd_idx + 1] (modulo N_STEPS)
// -----------------------------------------------------------------------------
module tone_sequencer_step_table
    import tone_sequencer_pkg::*;
#(
    parameter int N_STEPS = 8,
    parameter int IDX_W   = 3
) (
    input  logic             CLK_50M,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  step_t            wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output step_t            cur_step,
    output step_t            nxt_step
);

    step_t mem [N_STEPS];

    logic [IDX_W-1:0] nxt_idx;

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            for (int i = 0; i < N_STEPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Power-of-two table: the IDX_W-bit add wraps naturally.
    assign nxt_idx  = rd_idx + IDX_W'(1);
    assign cur_step = mem[rd_idx];
    assign nxt_step = mem[nxt_idx];

endmodule

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//   Plays a programmable sequence of divider terminal counts. Each table
//   entry holds count_to for dur CLK_50M cycles (PLAY), preceded by a single
//   LOAD cycle in which the divider is held in reset and count_to is updated.
//   A zero dur marks the end of the sequence; the table end also terminates
//   it. With loop_en high at the end of the last step the sequence restarts
//   from entry 0.
//
// Ports:
//   CLK_50M      in   system clock
//   reset        in   synchronous, active-high; also clears the table
//   wr_en        in   table write strobe (ignored while busy)
//   wr_addr      in   entry written
//   wr_count_to  in   divider terminal count for the entry
//   wr_dur       in   step duration in cycles, 0 = end marker
//   start        in   begin at entry 0 (level, sampled in IDLE only)
//   stop         in   abort to IDLE, no done pulse; wins over start
//   loop_en      in   restart at entry 0 after the last step
//   count_to     out  divider terminal count (held outside LOAD)
//   div_reset    out  divider reset, low only in PLAY
//   tone_on      out  high in PLAY
//   busy         out  high in LOAD and PLAY
//   done         out  one-cycle pulse on normal completion
//   step_idx     out  current entry
// -----------------------------------------------------------------------------
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int N_STEPS = 8,
    parameter int IDX_W   = 3
) (
    input  logic             CLK_50M,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [31:0]      wr_count_to,
    input  logic [31:0]      wr_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic [31:0]      count_to,
    output logic             div_reset,
    output logic             tone_on,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] step_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STEPS - 1);

    state_t      state;
    logic [31:0] dur_cnt;

    step_t       wr_step;
    step_t       cur_step;
    step_t       nxt_step;
    logic        tbl_wr;
    logic [31:0] first_dur;
    logic        step_end;
    logic        seq_end;

    // The table is only writable while no sequence is running.
    assign tbl_wr  = wr_en & ~busy;
    assign wr_step = {wr_count_to, wr_dur};

    tone_sequencer_step_table #(
        .N_STEPS (N_STEPS),
        .IDX_W   (IDX_W)
    ) u_table (
        .CLK_50M  (CLK_50M),
        .reset    (reset),
        .wr_en    (tbl_wr),
        .wr_addr  (wr_addr),
        .wr_data  (wr_step),
        .rd_idx   (step_idx),
        .cur_step (cur_step),
        .nxt_step (nxt_step)
    );

    // step_idx is always 0 in IDLE, so cur_step is entry 0 there. A write to
    // entry 0 in the same cycle as start is forwarded so the empty-sequence
    // decision agrees with what LOAD will read one cycle later.
    assign first_dur = (tbl_wr && (wr_addr == '0)) ? wr_dur : cur_step.dur;

    // Compare against dur-1 so dur = 0xFFFF_FFFF never needs a 33rd bit.
    assign step_end = (dur_cnt == (cur_step.dur - 32'd1));
    assign seq_end  = (step_idx == LAST_IDX) || (nxt_step.dur == END_MARKER_DUR);

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state    <= ST_IDLE;
            count_to <= '0;
            dur_cnt  <= '0;
            step_idx <= '0;
            {div_reset, tone_on, busy, done} <= state_flags(ST_IDLE);
        end else if (stop) begin
            // Abort: count_to keeps its last value, divider goes to reset.
            state    <= ST_IDLE;
            step_idx <= '0;
            {div_reset, tone_on, busy, done} <= state_flags(ST_IDLE);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        step_idx <= '0;
                        if (first_dur != END_MARKER_DUR) begin
                            state <= ST_LOAD;
                            {div_reset, tone_on, busy, done} <= state_flags(ST_LOAD);
                        end else begin
                            state <= ST_DONE;
                            {div_reset, tone_on, busy, done} <= state_flags(ST_DONE);
                        end
                    end
                end

                ST_LOAD: begin
                    count_to <= cur_step.count_to;
                    dur_cnt  <= '0;
                    state    <= ST_PLAY;
                    {div_reset, tone_on, busy, done} <= state_flags(ST_PLAY);
                end

                ST_PLAY: begin
                    if (step_end) begin
                        if (seq_end) begin
                            if (loop_en) begin
                                step_idx <= '0;
                                state    <= ST_LOAD;
                                {div_reset, tone_on, busy, done} <= state_flags(ST_LOAD);
                            end else begin
                                state <= ST_DONE;
                                {div_reset, tone_on, busy, done} <= state_flags(ST_DONE);
                            end
                        end else begin
                            step_idx <= step_idx + IDX_W'(1);
                            state    <= ST_LOAD;
                            {div_reset, tone_on, busy, done} <= state_flags(ST_LOAD);
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 32'd1;
                    end
                end

                ST_DONE: begin
                    step_idx <= '0;
                    state    <= ST_IDLE;
                    {div_reset, tone_on, busy, done} <= state_flags(ST_IDLE);
                end

                default: begin
                    step_idx <= '0;
                    state    <= ST_IDLE;
                    {div_reset, tone_on, busy, done} <= state_flags(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

    logic        CLK_50M = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_count_to;
    logic [31:0] wr_dur;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [31:0] count_to;
    logic        div_reset;
    logic        tone_on;
    logic        busy;
    logic        done;
    logic [2:0]  step_idx;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    tone_sequencer #(.N_STEPS(8), .IDX_W(3)) dut (
        .CLK_50M     (CLK_50M),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_count_to (wr_count_to),
        .wr_dur      (wr_dur),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .count_to    (count_to),
        .div_reset   (div_reset),
        .tone_on     (tone_on),
        .busy        (busy),
        .done        (done),
        .step_idx    (step_idx)
    );

    always #10 CLK_50M = ~CLK_50M;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one edge; outputs are then observed 1 ns after it.
    task automatic tick();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] c, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_count_to = c; wr_dur = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_cnt++; if ({count_to, div_reset, tone_on, busy, done, step_idx} !== {32'd0, 4'b1000, 3'd0})
            $display("FAIL reset_outputs: got ct=%0d dr=%b to=%b bz=%b dn=%b idx=%0d, want 0 1 0 0 0 0",
                     count_to, div_reset, tone_on, busy, done, step_idx);
        else pass_cnt++;
        // empty table: start goes straight to DONE
        start = 1'b1; tick(); start = 1'b0;
        chk_cnt++; if ({done, busy} !== 2'b10) $display("FAIL empty_done: got done=%b busy=%b, want 1 0", done, busy);
        else pass_cnt++;
        tick();
        chk_cnt++; if ({done, busy} !== 2'b00) $display("FAIL empty_after: got done=%b busy=%b, want 0 0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_write_with_start();
        // write e0 = {5, 1} in the same cycle as start
        wr_en = 1'b1; wr_addr = 3'd0; wr_count_to = 32'd5; wr_dur = 32'd1; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk_cnt++; if ({busy, tone_on, div_reset} !== 3'b101) $display("FAIL wws_load: got busy=%b tone=%b dr=%b, want 1 0 1", busy, tone_on, div_reset);
        else pass_cnt++;
        tick();
        chk_cnt++; if ({tone_on, div_reset, count_to} !== {2'b10, 32'd5}) $display("FAIL wws_play: got tone=%b dr=%b ct=%0d, want 1 0 5", tone_on, div_reset, count_to);
        else pass_cnt++;
        tick();
        chk_cnt++; if ({done, count_to} !== {1'b1, 32'd5}) $display("FAIL wws_done: got done=%b ct=%0d, want 1 5", done, count_to);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_sequence();
        int n4, n7, done_at;
        wr(3'd0, 32'd4, 32'd10);
        wr(3'd1, 32'd7, 32'd5);
        wr(3'd2, 32'd0, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk_cnt++; if ({busy, tone_on, div_reset, step_idx} !== {3'b101, 3'd0}) $display("FAIL seq_load0: got busy=%b tone=%b dr=%b idx=%0d, want 1 0 1 0", busy, tone_on, div_reset, step_idx);
        else pass_cnt++;
        n4 = 0; n7 = 0; done_at = -1;
        for (int t = 1; t <= 30 && done_at < 0; t++) begin
            tick();
            if (tone_on && !div_reset && count_to == 32'd4 && step_idx == 3'd0) n4++;
            if (tone_on && !div_reset && count_to == 32'd7 && step_idx == 3'd1) n7++;
            if (done) done_at = t;
        end
        chk_cnt++; if (n4 !== 10) $display("FAIL seq_e0_cycles: got %0d, want 10", n4); else pass_cnt++;
        chk_cnt++; if (n7 !== 5) $display("FAIL seq_e1_cycles: got %0d, want 5", n7); else pass_cnt++;
        chk_cnt++; if (done_at !== 17) $display("FAIL seq_done_at: got %0d, want 17", done_at); else pass_cnt++;
        chk_cnt++; if ({busy, count_to} !== {1'b0, 32'd7}) $display("FAIL seq_done_state: got busy=%b ct=%0d, want 0 7", busy, count_to); else pass_cnt++;
        tick();
        chk_cnt++; if ({done, step_idx} !== {1'b0, 3'd0}) $display("FAIL seq_idle: got done=%b idx=%0d, want 0 0", done, step_idx); else pass_cnt++;
    endtask

    task automatic test_loop();
        int done_at;
        logic [2:0] exp_idx;
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            exp_idx = ((t % 17) <= 10) ? 3'd0 : 3'd1;
            chk_cnt++; if ({step_idx, done, busy} !== {exp_idx, 2'b01})
                $display("FAIL loop_t%0d: got idx=%0d done=%b busy=%b, want %0d 0 1", t, step_idx, done, busy, exp_idx);
            else pass_cnt++;
        end
        loop_en = 1'b0;
        done_at = -1;
        for (int t = 41; t <= 80 && done_at < 0; t++) begin
            tick();
            if (done) done_at = t;
        end
        chk_cnt++; if (done_at !== 51) $display("FAIL loop_done_at: got %0d, want 51", done_at); else pass_cnt++;
        tick();
    endtask

    task automatic test_stop();
        logic bad;
        start = 1'b1; tick(); start = 1'b0;
        repeat (13) tick();
        chk_cnt++; if ({tone_on, count_to, step_idx} !== {1'b1, 32'd7, 3'd1}) $display("FAIL stop_pre: got tone=%b ct=%0d idx=%0d, want 1 7 1", tone_on, count_to, step_idx);
        else pass_cnt++;
        stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
        chk_cnt++; if ({busy, tone_on, div_reset, done, step_idx, count_to} !== {4'b0010, 3'd0, 32'd7})
            $display("FAIL stop_idle: got bz=%b to=%b dr=%b dn=%b idx=%0d ct=%0d, want 0 0 1 0 0 7", busy, tone_on, div_reset, done, step_idx, count_to);
        else pass_cnt++;
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (done || busy) bad = 1'b1;
        end
        chk_cnt++; if (bad !== 1'b0) $display("FAIL stop_quiet: got done/busy activity=%b, want 0", bad); else pass_cnt++;
    endtask

    task automatic test_write_busy();
        int n7, bad, done_at;
        for (int run = 0; run < 2; run++) begin
            start = 1'b1; tick(); start = 1'b0;
            n7 = 0; bad = 0; done_at = -1;
            for (int t = 1; t <= 40 && done_at < 0; t++) begin
                if (run == 0 && t == 3) begin
                    wr_en = 1'b1; wr_addr = 3'd1; wr_count_to = 32'd99; wr_dur = 32'd3;
                end
                tick();
                wr_en = 1'b0;
                if (tone_on && step_idx == 3'd1) begin
                    n7++;
                    if (count_to != 32'd7) bad++;
                end
                if (done) done_at = t;
            end
            chk_cnt++; if (bad !== 0) $display("FAIL wbusy_ct_run%0d: %0d cycles with count_to != 7 in step 1", run, bad); else pass_cnt++;
            chk_cnt++; if (n7 !== 5) $display("FAIL wbusy_len_run%0d: got %0d, want 5", run, n7); else pass_cnt++;
            chk_cnt++; if (done_at !== 17) $display("FAIL wbusy_done_run%0d: got %0d, want 17", run, done_at); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_full_table();
        logic [2:0] exp_idx;
        logic       exp_tone;
        for (int i = 0; i < 8; i++) wr(3'(i), 32'(i + 1), 32'd2);
        start = 1'b1; tick(); start = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (t > 0) tick();
            exp_idx  = 3'(t / 3);
            exp_tone = (t % 3) != 0;
            chk_cnt++; if ({step_idx, tone_on} !== {exp_idx, exp_tone})
                $display("FAIL full_t%0d: got idx=%0d tone=%b, want %0d %b", t, step_idx, tone_on, exp_idx, exp_tone);
            else pass_cnt++;
            if (exp_tone) begin
                chk_cnt++; if (count_to !== 32'(t / 3 + 1)) $display("FAIL full_ct_t%0d: got %0d, want %0d", t, count_to, t / 3 + 1);
                else pass_cnt++;
            end
        end
        tick();
        chk_cnt++; if ({done, count_to} !== {1'b1, 32'd8}) $display("FAIL full_done: got done=%b ct=%0d, want 1 8", done, count_to); else pass_cnt++;
        tick();
        chk_cnt++; if ({done, step_idx, busy} !== {1'b0, 3'd0, 1'b0}) $display("FAIL full_idle: got done=%b idx=%0d busy=%b, want 0 0 0", done, step_idx, busy); else pass_cnt++;
        // full table with looping wraps from entry 7 back to entry 0
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (24) tick();
        chk_cnt++; if ({step_idx, busy, done, tone_on} !== {3'd0, 3'b100}) $display("FAIL full_wrap: got idx=%0d busy=%b done=%b tone=%b, want 0 1 0 0", step_idx, busy, done, tone_on);
        else pass_cnt++;
        stop = 1'b1; tick(); stop = 1'b0; loop_en = 1'b0;
        chk_cnt++; if ({busy, done} !== 2'b00) $display("FAIL full_stop: got busy=%b done=%b, want 0 0", busy, done); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_count_to = '0; wr_dur = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        test_reset();
        test_write_with_start();
        test_sequence();
        test_loop();
        test_stop();
        test_write_busy();
        test_full_table();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
